// File: rtl/code_entry.sv
// Four-button combination lock: debounced button releases are collected as a
// four-digit entry, compared with CODE, and the verdict is held on o_input_states.
module code_entry #(
    parameter int         DEBOUNCE_LIMIT = 250000,
    parameter logic [7:0] CODE           = 8'b11100100,
    parameter int         HOLD_CYCLES    = 25000000,
    parameter int         TIMEOUT_CYCLES = 125000000
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Switch_1,
    input  logic       i_Switch_2,
    input  logic       i_Switch_3,
    input  logic       i_Switch_4,
    output logic [1:0] o_input_states
);

    localparam int DB_W   = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1)    ? $clog2(HOLD_CYCLES)    : 1;
    localparam int IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_LIMIT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] STATUS_IDLE  = 2'd0;
    localparam logic [1:0] STATUS_ENTRY = 2'd1;
    localparam logic [1:0] STATUS_BAD   = 2'd2;
    localparam logic [1:0] STATUS_GOOD  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_RESULT
    } state_t;

    logic [3:0]            sw_raw;
    logic [3:0]            sync_meta;
    logic [3:0]            sync_q;
    logic [3:0]            db_level;
    logic [3:0]            db_level_d;
    logic [3:0][DB_W-1:0]  db_cnt;
    logic [3:0]            press;
    logic                  press_any;
    logic [1:0]            press_digit;
    logic                  code_match;

    state_t                state;
    logic [2:0]            digit_cnt;
    logic [3:0][1:0]       digits;
    logic [HOLD_W-1:0]     hold_cnt;
    logic [IDLE_W-1:0]     idle_cnt;

    assign sw_raw = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            sync_meta <= '0;
            sync_q    <= '0;
        end else begin
            sync_meta <= sw_raw;
            sync_q    <= sync_meta;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            db_cnt     <= '0;
            db_level   <= '0;
            db_level_d <= '0;
        end else begin
            db_level_d <= db_level;
            for (int i = 0; i < 4; i++) begin
                if (sync_q[i] == db_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_level[i] <= sync_q[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // A press is the debounced release of a button, one cycle wide.
    assign press     = db_level_d & ~db_level;
    assign press_any = |press;

    // NOTE: defaults first so every path assigns press_digit and no latch is inferred.
    always_comb begin
        press_digit = 2'd0;
        if (press[0])      press_digit = 2'd0;
        else if (press[1]) press_digit = 2'd1;
        else if (press[2]) press_digit = 2'd2;
        else if (press[3]) press_digit = 2'd3;
    end

    // First three digits come from storage; the fourth is the one arriving now.
    assign code_match = ({press_digit, digits[2], digits[1], digits[0]} == CODE);

    // NOTE: the stored digits are ordinary flops and are cleared on reset, so an
    // interrupted entry can never leak old digits into the next comparison.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state          <= ST_IDLE;
            digit_cnt      <= '0;
            digits         <= '0;
            hold_cnt       <= '0;
            idle_cnt       <= '0;
            o_input_states <= STATUS_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (press_any) begin
                        digits[0]      <= press_digit;
                        digit_cnt      <= 3'd1;
                        idle_cnt       <= '0;
                        state          <= ST_ENTRY;
                        o_input_states <= STATUS_ENTRY;
                    end
                end
                ST_ENTRY: begin
                    if (press_any) begin
                        digits[digit_cnt[1:0]] <= press_digit;
                        digit_cnt              <= digit_cnt + 3'd1;
                        idle_cnt               <= '0;
                        if (digit_cnt == 3'd3) begin
                            hold_cnt       <= '0;
                            state          <= ST_RESULT;
                            o_input_states <= code_match ? STATUS_GOOD : STATUS_BAD;
                        end
                    end else if (idle_cnt == IDLE_LAST) begin
                        digit_cnt      <= '0;
                        idle_cnt       <= '0;
                        state          <= ST_IDLE;
                        o_input_states <= STATUS_IDLE;
                    end else if (idle_cnt != '1) begin
                        idle_cnt <= idle_cnt + IDLE_W'(1);
                    end
                end
                ST_RESULT: begin
                    // Presses here are dropped; returning to IDLE guarantees a 0 gap.
                    if (hold_cnt == HOLD_LAST) begin
                        digit_cnt      <= '0;
                        hold_cnt       <= '0;
                        state          <= ST_IDLE;
                        o_input_states <= STATUS_IDLE;
                    end else if (hold_cnt != '1) begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                default: begin
                    digit_cnt      <= '0;
                    state          <= ST_IDLE;
                    o_input_states <= STATUS_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_code_entry.sv
// Scoreboard bench for code_entry: stimulus feeds a timing-level model that queues
// expected status changes; a monitor pops and compares on every output change.
module tb_code_entry;

    localparam int         DEBOUNCE_LIMIT = 4;
    localparam logic [7:0] CODE           = 8'b11100100;
    localparam int         HOLD_CYCLES    = 8;
    localparam int         TIMEOUT_CYCLES = 50;

    logic       i_Clk   = 1'b0;
    logic       i_Reset = 1'b1;
    logic [3:0] sw      = 4'b0000;
    logic [1:0] o_input_states;

    code_entry #(
        .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT),
        .CODE           (CODE),
        .HOLD_CYCLES    (HOLD_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .i_Clk          (i_Clk),
        .i_Reset        (i_Reset),
        .i_Switch_1     (sw[0]),
        .i_Switch_2     (sw[1]),
        .i_Switch_3     (sw[2]),
        .i_Switch_4     (sw[3]),
        .o_input_states (o_input_states)
    );

    always #5 i_Clk = ~i_Clk;

    // Expected output change: new value plus the length the previous value must
    // have lasted (0 = length not checked).
    typedef struct {
        logic [1:0] val;
        int         prev_dur;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge i_Clk) cyc = cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push_exp(input logic [1:0] v, input int d);
        exp_t e;
        e.val      = v;
        e.prev_dur = d;
        sb.push_back(e);
    endfunction

    // ---------------- reference model (times are release cycles) ----------------
    int m_cnt       = 0;
    int m_digits[4];
    int m_t1        = 0;
    int m_tlast     = 0;
    int m_t4        = -100000;
    bit m_waive_hold = 1'b0;

    function automatic int code_digit(input int k);
        return int'((CODE >> (2 * k)) & 8'd3);
    endfunction

    function automatic void model_timeout_check(input int now);
        if (m_cnt > 0 && now - m_tlast > TIMEOUT_CYCLES) begin
            push_exp(2'd0, m_tlast + TIMEOUT_CYCLES - m_t1);
            m_cnt = 0;
        end
    endfunction

    function automatic void model_event(input int digit, input int t);
        bit ok;
        model_timeout_check(t);
        if (t - m_t4 >= 1 && t - m_t4 <= HOLD_CYCLES) return;
        if (m_cnt == 0) begin
            push_exp(2'd1, 0);
            m_t1 = t;
        end
        m_digits[m_cnt] = digit;
        m_cnt++;
        m_tlast = t;
        if (m_cnt == 4) begin
            ok = 1'b1;
            for (int k = 0; k < 4; k++)
                if (m_digits[k] != code_digit(k)) ok = 1'b0;
            push_exp(ok ? 2'd3 : 2'd2, t - m_t1);
            push_exp(2'd0, m_waive_hold ? 0 : HOLD_CYCLES);
            m_waive_hold = 1'b0;
            m_cnt        = 0;
            m_t4         = t;
        end
    endfunction

    always @(negedge i_Clk) model_timeout_check(cyc);

    // ---------------- monitor ----------------
    logic [1:0] prev_state = 2'd0;
    int         run_len    = 0;
    exp_t       mon_e;

    always @(negedge i_Clk) begin
        if (o_input_states !== prev_state) begin
            if (sb.size() == 0) begin
                check("unexpected_change", int'(o_input_states), int'(prev_state));
            end else begin
                mon_e = sb.pop_front();
                check("state_value", int'(o_input_states), int'(mon_e.val));
                if (mon_e.prev_dur != 0)
                    check("run_length", run_len, mon_e.prev_dur);
            end
            prev_state = o_input_states;
            run_len    = 1;
        end else begin
            run_len++;
        end
    end

    // ---------------- stimulus helpers (start and end on a negedge) ----------------
    task automatic press(input logic [3:0] mask, input int down, input int up);
        int d;
        d  = 0;
        sw = mask;
        repeat (down) @(negedge i_Clk);
        for (int i = 3; i >= 0; i--)
            if (mask[i]) d = i;
        sw = 4'b0000;
        model_event(d, cyc);
        repeat (up) @(negedge i_Clk);
    endtask

    task automatic enter_code(input int d0, input int d1, input int d2, input int d3);
        press(4'(1 << d0), 6, 8);
        press(4'(1 << d1), 6, 8);
        press(4'(1 << d2), 6, 8);
        press(4'(1 << d3), 6, 25);
    endtask

    task automatic reset_pulse();
        if (m_cnt > 0) push_exp(2'd0, 0);
        m_cnt = 0;
        m_t4  = -100000;
        #2 i_Reset = 1'b1;
        #1 check("reset_async", int'(o_input_states), 0);
        repeat (2) @(negedge i_Clk);
        i_Reset = 1'b0;
        repeat (2) @(negedge i_Clk);
    endtask

    task automatic wait_for_result(input logic [1:0] v);
        int w;
        w = 0;
        while (o_input_states !== v && w < 40) begin
            @(negedge i_Clk);
            w++;
        end
        check("result_arrives", int'(o_input_states), int'(v));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int dg[4];
        logic [3:0] mask;
        bit force_ok;

        // Reset with switch 1 already held: only its later release may count.
        sw = 4'b0001;
        repeat (3) @(negedge i_Clk);
        check("reset_state", int'(o_input_states), 0);
        i_Reset = 1'b0;
        repeat (10) @(negedge i_Clk);
        check("held_no_event", int'(o_input_states), 0);
        sw = 4'b0000;
        model_event(0, cyc);
        repeat (8) @(negedge i_Clk);
        press(4'b0010, 6, 8);
        press(4'b0100, 6, 8);
        press(4'b1000, 6, 25);

        // Two incorrect entries back to back.
        enter_code(0, 1, 2, 2);
        enter_code(0, 0, 0, 0);

        // Bounce on switch 2 must not register.
        for (int i = 0; i < 5; i++) begin
            sw = 4'b0010;
            repeat (2) @(negedge i_Clk);
            sw = 4'b0000;
            repeat (2) @(negedge i_Clk);
        end
        repeat (10) @(negedge i_Clk);
        check("bounce_idle", int'(o_input_states), 0);
        press(4'b0010, 6, 70);

        // Timeout after two digits, then a fresh correct entry.
        press(4'b0001, 6, 8);
        press(4'b0010, 6, 70);
        check("timeout_idle", int'(o_input_states), 0);
        enter_code(0, 1, 2, 3);

        // Simultaneous first press, and a press landing inside the result hold.
        press(4'b1001, 6, 8);
        press(4'b0010, 6, 8);
        press(4'b0100, 6, 8);
        sw = 4'b1100;
        repeat (7) @(negedge i_Clk);
        sw = 4'b0100;
        model_event(3, cyc);
        repeat (2) @(negedge i_Clk);
        sw = 4'b0000;
        model_event(2, cyc);
        repeat (25) @(negedge i_Clk);
        enter_code(0, 1, 2, 3);

        // Reset after two digits, then again three cycles into a hold.
        press(4'b0001, 6, 8);
        press(4'b0010, 6, 8);
        reset_pulse();
        press(4'b0001, 6, 8);
        press(4'b0010, 6, 8);
        press(4'b0100, 6, 8);
        m_waive_hold = 1'b1;
        press(4'b1000, 6, 0);
        wait_for_result(2'd3);
        repeat (3) @(negedge i_Clk);
        reset_pulse();
        enter_code(0, 1, 2, 3);

        // Randomized entries, some forced correct, some with extra simultaneous buttons.
        for (int n = 0; n < 12; n++) begin
            force_ok = ($urandom_range(0, 2) == 0);
            for (int k = 0; k < 4; k++)
                dg[k] = force_ok ? code_digit(k) : int'($urandom_range(0, 3));
            for (int k = 0; k < 4; k++) begin
                mask = 4'(1 << dg[k]);
                if (dg[k] < 3 && $urandom_range(0, 3) == 0)
                    mask = mask | 4'(1 << $urandom_range(dg[k] + 1, 3));
                press(mask, int'($urandom_range(6, 9)),
                      (k == 3) ? 30 : int'($urandom_range(6, 12)));
            end
        end

        repeat (20) @(negedge i_Clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
